frame_addr_sequencer: RTL and testbench

FRAME_ADDR_SEQUENCER -- requirements
Module: frame_addr_sequencer

---
 rtl/frame_pkg.sv | 20 ++
 rtl/pixel_pos_counter.sv | 76 +++++++
 rtl/frame_addr_sequencer.sv | 172 +++++++++++++++++
 tb/tb_frame_addr_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame address sequencer: FSM state encoding,
// default frame geometry, pixel width and the read-timeout limit.
package frame_pkg;

  localparam int H_PIXELS_DEF  = 640;
  localparam int V_LINES_DEF   = 480;
  localparam int ADDR_W_DEF    = 19;
  localparam int PIX_W         = 16;
  localparam int POS_W         = 10;
  localparam int TIMEOUT_LIMIT = 255;
  localparam int TMO_W         = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DATA = 2'd2,
    ADVANCE   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/pixel_pos_counter.sv
// Row/column/linear-address tracker. The linear address is stepped alongside
// the row/column pair so no multiplier is needed; Frame_Done pulses on wrap.
module pixel_pos_counter
  import frame_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [POS_W-1:0]  row_o,
  output logic [POS_W-1:0]  col_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              frame_done_o
);

  localparam logic [POS_W-1:0] COL_LAST = POS_W'(H_PIXELS - 1);
  localparam logic [POS_W-1:0] ROW_LAST = POS_W'(V_LINES - 1);

  logic [POS_W-1:0]  row_q, row_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              frame_done_q, frame_done_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the branches can infer a latch.
    row_d        = row_q;
    col_d        = col_q;
    addr_d       = addr_q;
    frame_done_d = 1'b0;
    if (clr_i) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d        = '0;
          addr_d       = '0;
          frame_done_d = 1'b1;
        end else begin
          row_d  = row_q + POS_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end else begin
        col_d  = col_q + POS_W'(1);
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q        <= '0;
      col_q        <= '0;
      addr_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      row_q        <= row_d;
      col_q        <= col_d;
      addr_q       <= addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign addr_o       = addr_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/frame_addr_sequencer.sv
// Walks a frame buffer pixel by pixel, issuing one SDRAM read or write per pixel.
// Optional read timeout is enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_addr_sequencer
  import frame_pkg::*;
#(
  parameter int H_PIXELS = H_PIXELS_DEF,
  parameter int V_LINES  = V_LINES_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Address_Reset,
  input  logic              Read,
  input  logic              Write,
  input  logic [PIX_W-1:0]  Wr_Data,
  input  logic              Busy,
  input  logic              Rd_Valid,
  input  logic [PIX_W-1:0]  Rd_Data,
  output logic              Sdram_Read,
  output logic              Sdram_Write,
  output logic [ADDR_W-1:0] Sdram_Addr,
  output logic [PIX_W-1:0]  Sdram_Wr_Data,
  output logic [POS_W-1:0]  Row_Data,
  output logic [POS_W-1:0]  Col_Data,
  output logic [PIX_W-1:0]  Pixel_Data,
  output logic              Pixel_Valid,
  output logic              Frame_Done,
  output logic              Seq_Busy,
  output logic              Rd_Error
);

  seq_state_e       state_q, state_d;
  logic             sdram_read_q, sdram_read_d;
  logic             sdram_write_q, sdram_write_d;
  logic [PIX_W-1:0] wr_data_q, wr_data_d;
  logic [PIX_W-1:0] pixel_data_q, pixel_data_d;
  logic             pixel_valid_q, pixel_valid_d;
  logic             pend_clr_q, pend_clr_d;
  logic             seq_busy_q, seq_busy_d;
  logic             pos_clr, pos_adv;
`ifdef FRAME_SEQ_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             rd_error_q, rd_error_d;
`endif

  always_comb begin
    state_d       = state_q;
    sdram_read_d  = sdram_read_q;
    sdram_write_d = sdram_write_q;
    wr_data_d     = wr_data_q;
    pixel_data_d  = pixel_data_q;
    pixel_valid_d = 1'b0;
    pend_clr_d    = pend_clr_q;
    pos_clr       = 1'b0;
    pos_adv       = 1'b0;
`ifdef FRAME_SEQ_TIMEOUT_EN
    tmo_cnt_d     = '0;
    rd_error_d    = 1'b0;
`endif

    // A restart seen mid-transaction is remembered and applied at ADVANCE.
    if (state_q != IDLE && Address_Reset) pend_clr_d = 1'b1;

    case (state_q)
      IDLE: begin
        if (Address_Reset) begin
          pos_clr = 1'b1;
        end else if (Read) begin
          state_d      = ISSUE;
          sdram_read_d = 1'b1;
        end else if (Write) begin
          state_d       = ISSUE;
          sdram_write_d = 1'b1;
          wr_data_d     = Wr_Data;
        end
      end
      ISSUE: begin
        if (!Busy) begin
          sdram_read_d  = 1'b0;
          sdram_write_d = 1'b0;
          state_d       = sdram_read_q ? WAIT_DATA : ADVANCE;
        end
      end
      WAIT_DATA: begin
        if (Rd_Valid) begin
          pixel_data_d  = Rd_Data;
          pixel_valid_d = 1'b1;
          state_d       = ADVANCE;
        end
`ifdef FRAME_SEQ_TIMEOUT_EN
        else if (tmo_cnt_q == TMO_W'(TIMEOUT_LIMIT - 1)) begin
          pixel_data_d  = {PIX_W{1'b1}};
          pixel_valid_d = 1'b1;
          rd_error_d    = 1'b1;
          state_d       = ADVANCE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end
      ADVANCE: begin
        if (pend_clr_q || Address_Reset) pos_clr = 1'b1;
        else                             pos_adv = 1'b1;
        pend_clr_d = 1'b0;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    seq_busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      sdram_read_q  <= 1'b0;
      sdram_write_q <= 1'b0;
      wr_data_q     <= '0;
      pixel_data_q  <= '0;
      pixel_valid_q <= 1'b0;
      pend_clr_q    <= 1'b0;
      seq_busy_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      sdram_read_q  <= sdram_read_d;
      sdram_write_q <= sdram_write_d;
      wr_data_q     <= wr_data_d;
      pixel_data_q  <= pixel_data_d;
      pixel_valid_q <= pixel_valid_d;
      pend_clr_q    <= pend_clr_d;
      seq_busy_q    <= seq_busy_d;
    end
  end

`ifdef FRAME_SEQ_TIMEOUT_EN
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      tmo_cnt_q  <= '0;
      rd_error_q <= 1'b0;
    end else begin
      tmo_cnt_q  <= tmo_cnt_d;
      rd_error_q <= rd_error_d;
    end
  end
  assign Rd_Error = rd_error_q;
`else
  assign Rd_Error = 1'b0;
`endif

  pixel_pos_counter #(
    .H_PIXELS (H_PIXELS),
    .V_LINES  (V_LINES),
    .ADDR_W   (ADDR_W)
  ) u_pos (
    .clk          (CLK),
    .rst_n        (Reset_n),
    .clr_i        (pos_clr),
    .adv_i        (pos_adv),
    .row_o        (Row_Data),
    .col_o        (Col_Data),
    .addr_o       (Sdram_Addr),
    .frame_done_o (Frame_Done)
  );

  assign Sdram_Read    = sdram_read_q;
  assign Sdram_Write   = sdram_write_q;
  assign Sdram_Wr_Data = wr_data_q;
  assign Pixel_Data    = pixel_data_q;
  assign Pixel_Valid   = pixel_valid_q;
  assign Seq_Busy      = seq_busy_q;

endmodule

// File: tb/tb_frame_addr_sequencer.sv
// Self-checking bench for frame_addr_sequencer on a scaled-down frame so full
// frame wraps fit in a short run; the model tracks position as one linear index.
module tb_frame_addr_sequencer;

  localparam int H    = 24;
  localparam int V    = 5;
  localparam int AW   = 19;
  localparam int NPIX = H * V;

  logic          CLK = 1'b0;
  logic          Reset_n = 1'b1;
  logic          Address_Reset = 1'b0;
  logic          Read = 1'b0;
  logic          Write = 1'b0;
  logic [15:0]   Wr_Data = '0;
  logic          Busy = 1'b0;
  logic          Rd_Valid = 1'b0;
  logic [15:0]   Rd_Data = '0;
  logic          Sdram_Read, Sdram_Write;
  logic [AW-1:0] Sdram_Addr;
  logic [15:0]   Sdram_Wr_Data;
  logic [9:0]    Row_Data, Col_Data;
  logic [15:0]   Pixel_Data;
  logic          Pixel_Valid, Frame_Done, Seq_Busy, Rd_Error;

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;

  frame_addr_sequencer #(
    .H_PIXELS (H),
    .V_LINES  (V),
    .ADDR_W   (AW)
  ) dut (
    .CLK           (CLK),
    .Reset_n       (Reset_n),
    .Address_Reset (Address_Reset),
    .Read          (Read),
    .Write         (Write),
    .Wr_Data       (Wr_Data),
    .Busy          (Busy),
    .Rd_Valid      (Rd_Valid),
    .Rd_Data       (Rd_Data),
    .Sdram_Read    (Sdram_Read),
    .Sdram_Write   (Sdram_Write),
    .Sdram_Addr    (Sdram_Addr),
    .Sdram_Wr_Data (Sdram_Wr_Data),
    .Row_Data      (Row_Data),
    .Col_Data      (Col_Data),
    .Pixel_Data    (Pixel_Data),
    .Pixel_Valid   (Pixel_Valid),
    .Frame_Done    (Frame_Done),
    .Seq_Busy      (Seq_Busy),
    .Rd_Error      (Rd_Error)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_pos(input string tag);
    check({tag, "_row"},  32'(Row_Data),   pos / H);
    check({tag, "_col"},  32'(Col_Data),   pos % H);
    check({tag, "_addr"}, 32'(Sdram_Addr), pos);
  endtask

  // One complete pixel transaction, checked cycle by cycle against the model.
  task automatic do_txn(input bit rd, input bit wr, input logic [15:0] d,
                        input int busy_n, input int rd_dly,
                        input bit ar_idle, input bit ar_mid);
    bit is_rd;
    bit fd;
    is_rd = rd;
    Read = rd; Write = wr; Wr_Data = d;
    if (ar_idle) begin
      Address_Reset = 1'b1;
      tick();
      Address_Reset = 1'b0;
      pos = 0;
      check("ar_idle_defer", 32'(Sdram_Read | Sdram_Write), 0);
      check("ar_idle_seq_busy", 32'(Seq_Busy), 0);
      check_pos("ar_idle");
    end
    tick();
    Read = 1'b0; Write = 1'b0; Wr_Data = 16'($urandom);
    check("strobe_rd", 32'(Sdram_Read), 32'(is_rd));
    check("strobe_wr", 32'(Sdram_Write), 32'(!is_rd));
    check("seq_busy_issue", 32'(Seq_Busy), 1);
    check_pos("issue");
    if (!is_rd) begin
      check("wr_data", 32'(Sdram_Wr_Data), 32'(d));
      Rd_Valid = 1'b1;
      Rd_Data  = 16'($urandom);
    end
    Busy = (busy_n > 0);
    for (int i = 1; i <= busy_n; i++) begin
      tick();
      Rd_Valid = 1'b0;
      check("strobe_held", 32'(is_rd ? Sdram_Read : Sdram_Write), 1);
      check("addr_stable", 32'(Sdram_Addr), pos);
      Busy = (i < busy_n);
    end
    if (ar_mid && !is_rd) Address_Reset = 1'b1;
    tick();
    Address_Reset = 1'b0;
    Rd_Valid = 1'b0;
    check("strobe_drop", 32'(Sdram_Read | Sdram_Write), 0);
    check("stray_valid_ignored", 32'(Pixel_Valid), 0);
    if (is_rd) begin
      if (ar_mid) Address_Reset = 1'b1;
      for (int i = 0; i < rd_dly; i++) begin
        tick();
        Address_Reset = 1'b0;
        check("no_early_valid", 32'(Pixel_Valid), 0);
      end
      Rd_Valid = 1'b1;
      Rd_Data  = d;
      tick();
      Rd_Valid = 1'b0;
      Address_Reset = 1'b0;
      Rd_Data = 16'($urandom);
      check("pixel_valid", 32'(Pixel_Valid), 1);
      check("pixel_data", 32'(Pixel_Data), 32'(d));
      check("seq_busy_adv", 32'(Seq_Busy), 1);
    end
    tick();
    fd  = !ar_mid && (pos == NPIX - 1);
    pos = ar_mid ? 0 : (pos + 1) % NPIX;
    check("frame_done", 32'(Frame_Done), 32'(fd));
    check("seq_busy_idle", 32'(Seq_Busy), 0);
    check("pixel_valid_pulse", 32'(Pixel_Valid), 0);
    check("rd_error_quiet", 32'(Rd_Error), 0);
    check_pos("advance");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit rd;
    #2 Reset_n = 1'b0;
    #20;
    check("rst_sdram_read",  32'(Sdram_Read), 0);
    check("rst_sdram_write", 32'(Sdram_Write), 0);
    check("rst_wr_data",     32'(Sdram_Wr_Data), 0);
    check("rst_pixel_data",  32'(Pixel_Data), 0);
    check("rst_pixel_valid", 32'(Pixel_Valid), 0);
    check("rst_frame_done",  32'(Frame_Done), 0);
    check("rst_seq_busy",    32'(Seq_Busy), 0);
    check("rst_rd_error",    32'(Rd_Error), 0);
    check_pos("rst");
    @(negedge CLK) Reset_n = 1'b1;
    tick();

    // Plain write at (0,0), then a stalled read returning 16'hABCD.
    do_txn(1'b0, 1'b1, 16'h1234, 0, 0, 1'b0, 1'b0);
    check("first_write_col", 32'(Col_Data), 1);
    do_txn(1'b1, 1'b0, 16'hABCD, 3, 2, 1'b0, 1'b0);

    // Read wins when both requests are high.
    do_txn(1'b1, 1'b1, 16'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), 1'b0, 1'b0);

    for (int k = 0; k < 20; k++) begin
      rd = 1'($urandom_range(0, 1));
      do_txn(rd, rd ? 1'($urandom_range(0, 1)) : 1'b1, 16'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 5), 1'b0, 1'b0);
    end

    // Address_Reset in IDLE defers the concurrent request by one cycle.
    do_txn(1'b1, 1'b0, 16'($urandom), 1, 1, 1'b1, 1'b0);
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b1, 1'b0);

    // Column wrap into row 1.
    while (pos != H - 1)
      do_txn(1'b0, 1'b1, 16'($urandom), $urandom_range(0, 1), 0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);
    check("row_wrap_addr", 32'(Sdram_Addr), H);

    // Frame wrap with Frame_Done pulse.
    while (pos != NPIX - 1)
      do_txn(1'b0, 1'b1, 16'($urandom), $urandom_range(0, 1), 0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);
    tick();
    check("frame_done_one_cycle", 32'(Frame_Done), 0);

    // Address_Reset mid-transaction: read in WAIT_DATA, write in ISSUE.
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);
    do_txn(1'b1, 1'b0, 16'($urandom), 1, 3, 1'b0, 1'b1);
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b1, 16'($urandom), 2, 0, 1'b0, 1'b1);

    // Address_Reset on the last pixel suppresses Frame_Done.
    while (pos != NPIX - 1)
      do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);
    do_txn(1'b1, 1'b0, 16'($urandom), 0, 2, 1'b0, 1'b1);

    // Reset asserted while a write is held in ISSUE.
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);
    do_txn(1'b1, 1'b0, 16'h5A5A, 0, 0, 1'b0, 1'b0);
    Write = 1'b1; Wr_Data = 16'hC0DE; Busy = 1'b1;
    tick();
    Write = 1'b0;
    tick();
    check("pre_reset_strobe", 32'(Sdram_Write), 1);
    #2 Reset_n = 1'b0;
    #1;
    check("mid_reset_strobe", 32'(Sdram_Write | Sdram_Read), 0);
    check("mid_reset_seq_busy", 32'(Seq_Busy), 0);
    check("mid_reset_pixel_data", 32'(Pixel_Data), 0);
    pos = 0;
    check_pos("mid_reset");
    Busy = 1'b0;
    @(negedge CLK) Reset_n = 1'b1;
    tick();
    do_txn(1'b0, 1'b1, 16'($urandom), 0, 0, 1'b0, 1'b0);

`ifdef FRAME_SEQ_TIMEOUT_EN
    // Read that never returns: timeout after 255 WAIT_DATA cycles.
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("tmo_strobe", 32'(Sdram_Read), 1);
    tick();
    for (int i = 0; i < 254; i++) tick();
    check("tmo_not_yet", 32'(Pixel_Valid | Rd_Error), 0);
    tick();
    check("tmo_rd_error", 32'(Rd_Error), 1);
    check("tmo_pixel_valid", 32'(Pixel_Valid), 1);
    check("tmo_pixel_data", 32'(Pixel_Data), 32'hFFFF);
    tick();
    pos = (pos + 1) % NPIX;
    check("tmo_rd_error_pulse", 32'(Rd_Error), 0);
    check_pos("tmo_advance");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
